lsu_bus_unit: RTL



---
 rtl/lsu_bus_unit_pkg.sv | 19 +
 rtl/lsu_bus_unit_lane_fmt.sv | 62 ++++++
 rtl/lsu_bus_unit.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/lsu_bus_unit_pkg.sv
// Shared encodings for the load/store bus unit: RISC-V funct3 width codes,
// the access FSM states and the default ack timeout.
package lsu_bus_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int MAX_WAIT_DEFAULT = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/lsu_bus_unit_lane_fmt.sv
// Combinational lane handling: store replication and byte enables, load lane
// extract with sign/zero extension, and the width/alignment fault check.
module lsu_lane_fmt
    import lsu_bus_unit_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        is_load_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o,
    output logic        fault_o
);

    logic        legal;
    logic [31:0] shifted;

    always_comb begin
        if (is_load_i) begin
            legal = (funct3_i == F3_B) || (funct3_i == F3_H) || (funct3_i == F3_W) ||
                    (funct3_i == F3_BU) || (funct3_i == F3_HU);
        end else begin
            legal = (funct3_i == F3_B) || (funct3_i == F3_H) || (funct3_i == F3_W);
        end
        fault_o = ~legal
                | ((funct3_i[1:0] == 2'b01) & addr_lo_i[0])
                | ((funct3_i[1:0] == 2'b10) & (addr_lo_i != 2'b00));
    end

    // Lane choice depends only on the access size, so loads and stores share it.
    always_comb begin
        unique case (funct3_i[1:0])
            2'b00: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
                wdata_o = {2{store_data_i[15:0]}};
            end
            default: begin
                be_o    = 4'b1111;
                wdata_o = store_data_i;
            end
        endcase
    end

    always_comb begin
        shifted = rdata_i >> {addr_lo_i, 3'b000};
        unique case (funct3_i)
            F3_B:    load_data_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   load_data_o = {24'd0, shifted[7:0]};
            F3_H:    load_data_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   load_data_o = {16'd0, shifted[15:0]};
            F3_W:    load_data_o = rdata_i;
            default: load_data_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/lsu_bus_unit.sv
// Multi-cycle load/store unit: issues one req/ack bus access per MEM
// instruction, stalls the pipeline until it completes, and formats load data.
module lsu_bus_unit
    import lsu_bus_unit_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] store_data_i,
    input  logic        flush_i,
    output logic [31:0] load_data_o,
    output logic        stall_o,
    output logic        misaligned_o,
    output logic        bus_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i
);

    localparam logic [7:0] CNT_LAST = 8'(MAX_WAIT - 1);

    lsu_state_e  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  lo_q, lo_d;
    logic        ld_q, ld_d;
    logic [31:0] ldata_q, ldata_d;
    logic        err_q, err_d;

    logic        access;
    logic [2:0]  fmt_f3;
    logic [1:0]  fmt_lo;
    logic        fmt_ld;
    logic [3:0]  fmt_be;
    logic [31:0] fmt_wdata;
    logic [31:0] fmt_ldata;
    logic        fmt_fault;

    assign access = (MemRead_i | MemWrite_i) & ~flush_i;

    // One formatter serves both phases: live inputs at issue, latched op while waiting for ack.
    assign fmt_f3 = (state_q == REQ) ? f3_q : funct3_i;
    assign fmt_lo = (state_q == REQ) ? lo_q : addr_i[1:0];
    assign fmt_ld = (state_q == REQ) ? ld_q : MemRead_i;

    lsu_lane_fmt u_lane_fmt (
        .funct3_i     (fmt_f3),
        .addr_lo_i    (fmt_lo),
        .is_load_i    (fmt_ld),
        .store_data_i (store_data_i),
        .rdata_i      (mem_rdata_i),
        .be_o         (fmt_be),
        .wdata_o      (fmt_wdata),
        .load_data_o  (fmt_ldata),
        .fault_o      (fmt_fault)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_d        = req_q;
        we_d         = we_q;
        addr_d       = addr_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        f3_d         = f3_q;
        lo_d         = lo_q;
        ld_d         = ld_q;
        ldata_d      = ldata_q;
        err_d        = 1'b0;
        stall_o      = 1'b0;
        misaligned_o = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (access) begin
                    if (fmt_fault) begin
                        misaligned_o = 1'b1;
                        ldata_d      = 32'd0;
                    end else begin
                        stall_o = 1'b1;
                        req_d   = 1'b1;
                        we_d    = MemWrite_i & ~MemRead_i;
                        addr_d  = {addr_i[31:2], 2'b00};
                        be_d    = fmt_be;
                        wdata_d = fmt_wdata;
                        f3_d    = funct3_i;
                        lo_d    = addr_i[1:0];
                        ld_d    = MemRead_i;
                        cnt_d   = 8'd0;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                stall_o = 1'b1;
                if (mem_ack_i) begin
                    req_d   = 1'b0;
                    state_d = DONE;
                    if (ld_q) begin
                        ldata_d = fmt_ldata;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    ldata_d = 32'd0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            f3_q    <= 3'd0;
            lo_q    <= 2'd0;
            ld_q    <= 1'b0;
            ldata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            lo_q    <= lo_d;
            ld_q    <= ld_d;
            ldata_q <= ldata_d;
            err_q   <= err_d;
        end
    end

    assign load_data_o = ldata_q;
    assign bus_err_o   = err_q;
    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_be_o    = be_q;
    assign mem_wdata_o = wdata_q;

endmodule
